// File: rtl/ahb_matrix_pkg.sv
// ahb_matrix_pkg: shared HTRANS encodings, port-count bounds and index-width helper
package ahb_matrix_pkg;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam int NUM_PORTS_MIN = 2;
    localparam int NUM_PORTS_MAX = 16;
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational rotate-priority pick, scanning from i_start+1 and ending at i_start
module ahb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_idx,
    output logic         o_found
);
    // walk from farthest to nearest so the nearest requester after i_start wins
    always_comb begin
        int j;
        j = 0;
        o_idx = i_start;
        o_found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            j = int'(i_start) + k;
            if (j >= N) j = j - N;
            if (i_req[j]) begin
                o_idx = W'(j);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_matrix_output_arbiter.sv
// ahb_matrix_output_arbiter: round-robin owner/data-phase tracking for one bus-matrix output port
module ahb_matrix_output_arbiter
    import ahb_matrix_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W = idx_w(NUM_PORTS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_PORTS-1:0]   sel_op,
    input  logic [2*NUM_PORTS-1:0] trans_op,
    input  logic [NUM_PORTS-1:0]   mastlock_op,
    input  logic                   HREADYM,
    output logic [PORT_W-1:0]      addr_in_port,
    output logic                   no_port,
    output logic [NUM_PORTS-1:0]   active_op,
    output logic [PORT_W-1:0]      data_in_port,
    output logic                   data_valid
);
    logic [PORT_W-1:0] r_addr;
    logic              r_no_port;
    logic [PORT_W-1:0] r_data;
    logic              r_data_valid;
    logic              w_own_sel;
    logic              w_own_lock;
    logic [1:0]        w_own_trans;
    logic              w_hold;
    logic [PORT_W-1:0] w_pick_idx;
    logic              w_pick_found;

    // select the current owner's request signals without out-of-range indexing
    always_comb begin
        w_own_sel = 1'b0;
        w_own_lock = 1'b0;
        w_own_trans = TRANS_IDLE;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_addr == PORT_W'(i)) begin
                w_own_sel = sel_op[i];
                w_own_lock = mastlock_op[i];
                w_own_trans = trans_op[2*i +: 2];
            end
        end
    end

    assign w_hold = ~r_no_port & w_own_sel &
                    ((w_own_trans == TRANS_BUSY) | (w_own_trans == TRANS_SEQ) | w_own_lock);

    ahb_rr_pick #(.N(NUM_PORTS), .W(PORT_W)) u_pick (
        .i_req   (sel_op),
        .i_start (r_addr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // address and data phase ownership advance only when the MI accepts a transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr <= '0;
            r_no_port <= 1'b1;
            r_data <= '0;
            r_data_valid <= 1'b0;
        end else if (HREADYM) begin
            r_data <= r_addr;
            r_data_valid <= ~r_no_port & (w_own_trans != TRANS_IDLE);
            if (!w_hold) begin
                r_addr <= w_pick_found ? w_pick_idx : r_addr;
                r_no_port <= ~w_pick_found;
            end
        end
    end

    // one-hot owner indication decoded from registered state only
    always_comb begin
        active_op = '0;
        for (int i = 0; i < NUM_PORTS; i++) active_op[i] = ~r_no_port & (r_addr == PORT_W'(i));
    end

    assign addr_in_port = r_addr;
    assign no_port = r_no_port;
    assign data_in_port = r_data;
    assign data_valid = r_data_valid;
endmodule

// File: tb/tb_ahb_matrix_output_arbiter.sv
// tb_ahb_matrix_output_arbiter: randomized and directed checks of 4- and 3-port arbiters against a reference model
module tb_ahb_matrix_output_arbiter;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [3:0] sel = '0;
    logic [7:0] trans = '0;
    logic [3:0] lock = '0;
    logic       rdy = 1'b1;
    logic [1:0] a4, d4, a3, d3;
    logic       n4, v4, n3, v3;
    logic [3:0] act4;
    logic [2:0] act3;
    int checks = 0;
    int failures = 0;
    int np [2] = '{4, 3};
    int m_addr [2];
    int m_data [2];
    int m_nop [2];
    int m_dv [2];

    always #5 HCLK = ~HCLK;

    ahb_matrix_output_arbiter #(.NUM_PORTS(4), .PORT_W(2)) u4 (
        .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel), .trans_op(trans),
        .mastlock_op(lock), .HREADYM(rdy), .addr_in_port(a4), .no_port(n4),
        .active_op(act4), .data_in_port(d4), .data_valid(v4)
    );

    ahb_matrix_output_arbiter #(.NUM_PORTS(3), .PORT_W(2)) u3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel[2:0]), .trans_op(trans[5:0]),
        .mastlock_op(lock[2:0]), .HREADYM(rdy), .addr_in_port(a3), .no_port(n3),
        .active_op(act3), .data_in_port(d3), .data_valid(v3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_addr[c] = 0;
            m_nop[c] = 1;
            m_data[c] = 0;
            m_dv[c] = 0;
        end
    endtask

    function automatic int tr(input int p);
        return int'((trans >> (2*p)) & 8'd3);
    endfunction

    // a port keeps the bus mid-burst or while locked; otherwise the next requester after it in ring order wins
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            int n, own, t;
            bit hold, found;
            n = np[c];
            own = m_addr[c];
            t = tr(own);
            hold = !m_nop[c] && sel[own] && (t == 1 || t == 3 || lock[own]);
            if (rdy) begin
                m_data[c] = own;
                m_dv[c] = (!m_nop[c] && t != 0) ? 1 : 0;
                if (!hold) begin
                    found = 0;
                    for (int k = 1; k <= n; k++)
                        if (!found && sel[(own + k) % n]) begin
                            found = 1;
                            m_addr[c] = (own + k) % n;
                        end
                    m_nop[c] = found ? 0 : 1;
                end
            end
        end
    endtask

    task automatic cmp_all();
        chk("addr4", 32'(a4), 32'(m_addr[0]));
        chk("nop4", 32'(n4), 32'(m_nop[0]));
        chk("act4", 32'(act4), m_nop[0] ? 32'd0 : 32'(1 << m_addr[0]));
        chk("data4", 32'(d4), 32'(m_data[0]));
        chk("dv4", 32'(v4), 32'(m_dv[0]));
        chk("addr3", 32'(a3), 32'(m_addr[1]));
        chk("nop3", 32'(n3), 32'(m_nop[1]));
        chk("act3", 32'(act3), m_nop[1] ? 32'd0 : 32'(1 << m_addr[1]));
        chk("data3", 32'(d3), 32'(m_data[1]));
        chk("dv3", 32'(v3), 32'(m_dv[1]));
    endtask

    task automatic cyc(input logic [3:0] s, input logic [7:0] t, input logic [3:0] l, input logic r);
        sel = s;
        trans = t;
        lock = l;
        rdy = r;
        @(posedge HCLK);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic async_reset();
        @(posedge HCLK);
        #3;
        HRESETn = 1'b0;
        #1;
        model_reset();
        cmp_all();
        chk("rst_nop4_now", 32'(n4), 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        cmp_all();
        @(negedge HCLK);
        HRESETn = 1'b1;
        // idle: nothing requested
        repeat (5) cyc(4'b0000, 8'h00, 4'b0000, 1'b1);
        chk("idle_nop", 32'(n4), 32'd1);
        // ports 0 and 2 together from reset: scan from 1 picks 2, then rotation returns to 0
        cyc(4'b0101, 8'b00_10_00_10, 4'b0000, 1'b1);
        chk("rr_first", 32'(a4), 32'd2);
        cyc(4'b0101, 8'b00_10_00_10, 4'b0000, 1'b1);
        chk("rr_second", 32'(a4), 32'd0);
        // port 1 burst with port 3 requesting throughout
        cyc(4'b1010, 8'b10_00_10_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_10_00, 4'b0000, 1'b1);
        // port 1 burst stalled by wait states and a BUSY beat
        cyc(4'b0010, 8'b00_00_10_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
        chk("burst_own", 32'(a4), 32'd1);
        repeat (3) cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b0);
        chk("stall_own", 32'(a4), 32'd1);
        cyc(4'b1010, 8'b10_00_01_00, 4'b0000, 1'b1);
        cyc(4'b1010, 8'b10_00_11_00, 4'b0000, 1'b1);
        chk("busy_own", 32'(a4), 32'd1);
        cyc(4'b1010, 8'b10_00_00_00, 4'b0000, 1'b1);
        chk("burst_rel", 32'(a4), 32'd3);
        // port 0 locked across IDLE while port 1 requests
        cyc(4'b0001, 8'b00_00_00_10, 4'b0001, 1'b1);
        chk("lock_grant", 32'(a4), 32'd0);
        repeat (4) cyc(4'b0011, 8'b00_00_10_00, 4'b0001, 1'b1);
        chk("lock_hold", 32'(a4), 32'd0);
        cyc(4'b0011, 8'b00_00_10_00, 4'b0000, 1'b1);
        chk("lock_rel", 32'(a4), 32'd1);
        // 3-port wrap: owner 2, ports 0 and 1 request
        cyc(4'b0100, 8'b00_10_00_00, 4'b0000, 1'b1);
        chk("wrap_own2", 32'(a3), 32'd2);
        cyc(4'b0011, 8'b00_00_10_10, 4'b0000, 1'b1);
        chk("wrap_own0", 32'(a3), 32'd0);
        // asynchronous reset in the middle of a locked burst
        cyc(4'b0110, 8'b00_11_11_00, 4'b0110, 1'b1);
        sel = 4'b0110;
        async_reset();
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) async_reset();
            else cyc(4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                     $urandom_range(0, 3) != 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
